grf_writeback: RTL and testbench
================================

Name: grf_writeback

Overview:
- Writeback pipeline stage: the writer side of the grf write port.
- Captures MEM-stage results into the MEM/WB register. Selects the ALU result, load data with extension, or PC+8.
- Drives writeEnable/writeReg/writeData/PCReg into grf one cycle after capture.
- Exports the same registered values as a forwarding source for the decode/execute bypass, plus a retired-instruction counter.

Parameters:
- RESET_PC, 32'h00003000, value of PCReg after reset or for a bubble.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- inValid  in  1  MEM stage holds a real instruction
- inPC  in  32  PC of that instruction
- inRegWrite  in  1  instruction writes a GPR
- inWriteReg  in  5  destination GPR index
- inWbSel  in  2  0=ALU, 1=MEM, 2=PC8, 3=reserved (treated as ALU)
- inAluResult  in  32  ALU/address result
- inMemData  in  32  raw word read from DM
- inLoadType  in  3  0=lw, 1=lb, 2=lbu, 3=lh, 4=lhu, others=lw
- inAddrLow  in  2  byte offset of the load address
- hold  in  1  freeze the stage register (mult/div or global stall)
- flush  in  1  replace the captured instruction with a bubble
- writeEnable  out  1  grf write enable
- writeReg  out  5  grf write index
- writeData  out  32  grf write data
- PCReg  out  32  PC of the instruction being written, for the grf trace
- fwdValid  out  1  forwarding data valid (writeEnable and writeReg != 0)
- fwdReg  out  5  forwarding register index
- fwdData  out  32  forwarding data (equals writeData)
- misalign  out  1  one-cycle pulse: captured load was misaligned
- retired  out  CNT_W  count of retired (non-bubble) instructions

Behaviour:
- Priority on each rising clk edge: reset > flush > hold > load.
- Reset:
  - writeEnable=0, writeReg=0, writeData=0, PCReg=RESET_PC.
  - fwdValid=0, misalign=0, retired=0.
- Flush, or load with inValid=0, captures a bubble:
  - writeEnable=0, writeReg=0, writeData=0, PCReg=RESET_PC, misalign=0.
  - retired unchanged.
- Hold: all registers keep their value. misalign is cleared to 0 so it never pulses twice. retired is unchanged.
- Load with inValid=1 and no misalignment:
  - writeEnable = inRegWrite and (inWriteReg != 0).
  - writeReg = inWriteReg; PCReg = inPC; retired increments by 1, wrapping to 0 at 2^CNT_W.
- writeData selection:
  - ALU: inAluResult.
  - PC8: inPC+8, modulo 2^32.
  - MEM: little-endian extract from inMemData, then extend:
    - lb/lbu: byte [8*inAddrLow +: 8], sign- or zero-extended.
    - lh/lhu: half [16*inAddrLow[1] +: 16], sign- or zero-extended.
    - lw: full word.
- Misalignment applies only when inWbSel=MEM. It occurs for lh/lhu with inAddrLow[0]=1, and for lw with inAddrLow != 0.
  - A misaligned load is captured with writeEnable=0, writeData=0, PCReg=inPC.
  - misalign=1 for exactly one cycle; retired still increments.
- Latency: inputs to grf/forwarding outputs is exactly 1 cycle. All outputs are registered; fwd* are combinational copies of registered state.
- Register 0 is never written: writeEnable=0 and fwdValid=0 even if inRegWrite=1. writeData still reflects the selected value.
- Reset asserted during hold or flush: reset wins and all state clears the same cycle.
- Flush and hold together: bubble is captured (flush wins).

Decomposition:
- Shared package mips_defs holds the constants:
  - WB_ALU/WB_MEM/WB_PC8
  - LD_LW/LD_LB/LD_LBU/LD_LH/LD_LHU
  - RESET_PC value
- One natural sub-module, load_extender: combinational; inputs inMemData, inLoadType, inAddrLow; outputs extended data and a misalign flag.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, inValid=0 -> writeEnable=0, PCReg=32'h00003000, retired=0.
- ALU write: inPC=32'h00003004, inRegWrite=1, inWriteReg=10, inWbSel=ALU, inAluResult=16 -> next cycle writeEnable=1, writeReg=10, writeData=16, fwdValid=1, retired=1.
- $0 suppression: inWriteReg=0, inAluResult=3, inRegWrite=1 -> writeEnable=0, fwdValid=0, writeData=3, retired increments.
- Loads with inMemData=32'h80FF7F01:
  - lb, addrLow=3 -> 32'hFFFFFF80
  - lbu, addrLow=1 -> 32'h0000007F
  - lh, addrLow=2 -> 32'hFFFF80FF
  - lhu, addrLow=0 -> 32'h00007F01
- Misaligned and jal:
  - lw, addrLow=2 -> writeEnable=0, misalign pulses for 1 cycle.
  - jal with inPC=32'hFFFFFFFC, inWriteReg=31, inWbSel=PC8 -> writeData=32'h00000004.
- Hold/flush/reset interplay:
  - hold=1 for 3 cycles -> outputs frozen, retired frozen.
  - flush=1 with hold=1 -> bubble.
  - reset=1 with flush=1 -> reset state.
  - retired preset to 32'hFFFFFFFF, then one valid instruction -> retired=0.

Source files
------------

// File: rtl/mips_defs.sv
// Shared writeback-path constants: writeback source select, load types and reset PC.
package mips_defs;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_MEM  = 2'd1,
        WB_PC8  = 2'd2,
        WB_RSVD = 2'd3
    } wbSel_e;

    typedef enum logic [2:0] {
        LD_LW  = 3'd0,
        LD_LB  = 3'd1,
        LD_LBU = 3'd2,
        LD_LH  = 3'd3,
        LD_LHU = 3'd4
    } loadType_e;

    localparam logic [31:0] RESET_PC_INIT = 32'h0000_3000;

    // Contents of the MEM/WB stage register.
    typedef struct packed {
        logic        writeEnable;
        logic [4:0]  writeReg;
        logic [31:0] writeData;
        logic [31:0] pc;
        logic        misalign;
    } wbStage_t;

    function automatic wbStage_t bubbleStage(input logic [31:0] resetPc);
        wbStage_t s;
        s.writeEnable = 1'b0;
        s.writeReg    = 5'd0;
        s.writeData   = 32'd0;
        s.pc          = resetPc;
        s.misalign    = 1'b0;
        return s;
    endfunction

endpackage

// File: rtl/grf_writeback_if.sv
// MEM-stage inputs, stage controls and grf/forwarding outputs of the writeback stage.
interface grf_writeback_if #(
    parameter int unsigned CNT_W = 32
);
    logic             inValid;
    logic [31:0]      inPC;
    logic             inRegWrite;
    logic [4:0]       inWriteReg;
    logic [1:0]       inWbSel;
    logic [31:0]      inAluResult;
    logic [31:0]      inMemData;
    logic [2:0]       inLoadType;
    logic [1:0]       inAddrLow;
    logic             hold;
    logic             flush;
    logic             writeEnable;
    logic [4:0]       writeReg;
    logic [31:0]      writeData;
    logic [31:0]      PCReg;
    logic             fwdValid;
    logic [4:0]       fwdReg;
    logic [31:0]      fwdData;
    logic             misalign;
    logic [CNT_W-1:0] retired;

    modport master (
        output inValid, inPC, inRegWrite, inWriteReg, inWbSel, inAluResult,
               inMemData, inLoadType, inAddrLow, hold, flush,
        input  writeEnable, writeReg, writeData, PCReg, fwdValid, fwdReg,
               fwdData, misalign, retired
    );

    modport slave (
        input  inValid, inPC, inRegWrite, inWriteReg, inWbSel, inAluResult,
               inMemData, inLoadType, inAddrLow, hold, flush,
        output writeEnable, writeReg, writeData, PCReg, fwdValid, fwdReg,
               fwdData, misalign, retired
    );
endinterface

// File: rtl/load_extender.sv
// Little-endian byte/half extraction with sign or zero extension, plus the
// alignment check for the access size.
module load_extender
    import mips_defs::*;
(
    input  logic [31:0] inMemData,
    input  logic [2:0]  inLoadType,
    input  logic [1:0]  inAddrLow,
    output logic [31:0] extData,
    output logic        misalign
);
    logic [7:0]  byteVal;
    logic [15:0] halfVal;

    always_comb begin
        byteVal  = 8'(inMemData >> {inAddrLow, 3'b000});
        halfVal  = 16'(inMemData >> {inAddrLow[1], 4'b0000});
        extData  = inMemData;
        misalign = 1'b0;
        case (inLoadType)
            LD_LB:  extData = {{24{byteVal[7]}}, byteVal};
            LD_LBU: extData = {24'd0, byteVal};
            LD_LH: begin
                extData  = {{16{halfVal[15]}}, halfVal};
                misalign = inAddrLow[0];
            end
            LD_LHU: begin
                extData  = {16'd0, halfVal};
                misalign = inAddrLow[0];
            end
            // lw and every unassigned encoding behave as a full-word load
            default: misalign = (inAddrLow != 2'd0);
        endcase
    end

endmodule

// File: rtl/grf_writeback.sv
// Writeback stage: MEM/WB register feeding the grf write port, the bypass
// network and a retired-instruction counter.
module grf_writeback
    import mips_defs::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_INIT,
    parameter int unsigned CNT_W    = 32
) (
    input logic            clk,
    input logic            reset,
    grf_writeback_if.slave bus
);
    localparam wbStage_t Bubble = bubbleStage(RESET_PC);

    wbStage_t         stageQ, stageD;
    logic [CNT_W-1:0] retiredQ, retiredD;
    logic [31:0]      extData;
    logic [31:0]      selData;
    logic             ldMisalign;
    logic             memMisalign;

    load_extender uLoadExtender (
        .inMemData  (bus.inMemData),
        .inLoadType (bus.inLoadType),
        .inAddrLow  (bus.inAddrLow),
        .extData    (extData),
        .misalign   (ldMisalign)
    );

    always_comb begin
        case (bus.inWbSel)
            WB_MEM:  selData = extData;
            WB_PC8:  selData = bus.inPC + 32'd8;
            default: selData = bus.inAluResult;
        endcase
        memMisalign = (bus.inWbSel == WB_MEM) && ldMisalign;
    end

    always_comb begin
        stageD          = stageQ;
        // Cleared on every non-capture edge so a misalign flag pulses only once.
        stageD.misalign = 1'b0;
        retiredD        = retiredQ;
        if (bus.flush || (!bus.hold && !bus.inValid)) begin
            stageD = Bubble;
        end else if (!bus.hold) begin
            retiredD        = retiredQ + CNT_W'(1);
            stageD.writeReg = bus.inWriteReg;
            stageD.pc       = bus.inPC;
            stageD.misalign = memMisalign;
            if (memMisalign) begin
                stageD.writeEnable = 1'b0;
                stageD.writeData   = 32'd0;
            end else begin
                stageD.writeEnable = bus.inRegWrite && (bus.inWriteReg != 5'd0);
                stageD.writeData   = selData;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stageQ   <= Bubble;
            retiredQ <= '0;
        end else begin
            stageQ   <= stageD;
            retiredQ <= retiredD;
        end
    end

    assign bus.writeEnable = stageQ.writeEnable;
    assign bus.writeReg    = stageQ.writeReg;
    assign bus.writeData   = stageQ.writeData;
    assign bus.PCReg       = stageQ.pc;
    assign bus.misalign    = stageQ.misalign;
    assign bus.fwdValid    = stageQ.writeEnable && (stageQ.writeReg != 5'd0);
    assign bus.fwdReg      = stageQ.writeReg;
    assign bus.fwdData     = stageQ.writeData;
    assign bus.retired     = retiredQ;

endmodule

// File: tb/tb_grf_writeback.sv
// Self-checking bench for grf_writeback: directed vector table, hand-written
// hold/flush/reset/wrap sequences and randomized stimulus against a reference model.
module tb_grf_writeback;
    localparam logic [31:0] RPC = 32'h0000_3000;
    localparam logic [31:0] M   = 32'h80FF_7F01;
    localparam int          NV  = 15;

    logic clk = 1'b0;
    logic reset;

    grf_writeback_if #(.CNT_W(32)) bus ();
    grf_writeback_if #(.CNT_W(4))  bus2 ();

    grf_writeback #(.RESET_PC(RPC), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Narrow-counter copy fed identical stimulus, so counter wrap is reachable.
    grf_writeback #(.RESET_PC(RPC), .CNT_W(4)) dutSmall (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    assign bus2.inValid     = bus.inValid;
    assign bus2.inPC        = bus.inPC;
    assign bus2.inRegWrite  = bus.inRegWrite;
    assign bus2.inWriteReg  = bus.inWriteReg;
    assign bus2.inWbSel     = bus.inWbSel;
    assign bus2.inAluResult = bus.inAluResult;
    assign bus2.inMemData   = bus.inMemData;
    assign bus2.inLoadType  = bus.inLoadType;
    assign bus2.inAddrLow   = bus.inAddrLow;
    assign bus2.hold        = bus.hold;
    assign bus2.flush       = bus.flush;

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic        rw;
        logic [4:0]  wr;
        logic [1:0]  sel;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [2:0]  lt;
        logic [1:0]  al;
        logic        eWe;
        logic [4:0]  eReg;
        logic [31:0] eData;
        logic [31:0] ePc;
        logic        eMis;
    } vec_t;

    vec_t  vecs [NV];
    int    nChecks = 0;
    int    nErrors = 0;
    string curTag  = "";

    // Reference model state
    logic        mWe, mMis, mKnown;
    logic [4:0]  mReg;
    logic [31:0] mData, mPc, mRet;
    logic [3:0]  mRet2;

    function automatic vec_t mkv(logic valid, logic [31:0] pc, logic rw, logic [4:0] wr,
                                 logic [1:0] sel, logic [31:0] alu, logic [31:0] mem,
                                 logic [2:0] lt, logic [1:0] al, logic eWe, logic [4:0] eReg,
                                 logic [31:0] eData, logic [31:0] ePc, logic eMis);
        vec_t v;
        v.valid = valid; v.pc = pc; v.rw = rw; v.wr = wr; v.sel = sel; v.alu = alu;
        v.mem = mem; v.lt = lt; v.al = al; v.eWe = eWe; v.eReg = eReg; v.eData = eData;
        v.ePc = ePc; v.eMis = eMis;
        return v;
    endfunction

    function automatic logic [31:0] loadValue(input logic [31:0] mem, input int lt,
                                              input int addr);
        logic [31:0] b, h;
        b = (mem >> (8 * addr)) % 256;
        h = (mem >> (16 * (addr / 2))) % 65536;
        case (lt)
            1:       return (b >= 128) ? b - 256 : b;
            2:       return b;
            3:       return (h >= 32768) ? h - 65536 : h;
            4:       return h;
            default: return mem;
        endcase
    endfunction

    function automatic bit isMisaligned(input int sel, input int lt, input int addr);
        if (sel != 1) return 1'b0;
        if (lt == 1 || lt == 2) return 1'b0;
        if (lt == 3 || lt == 4) return (addr % 2) == 1;
        return addr != 0;
    endfunction

    task automatic modelEdge();
        if (reset) begin
            mWe = 1'b0; mReg = 5'd0; mData = 32'd0; mPc = RPC; mMis = 1'b0;
            mKnown = 1'b1; mRet = 32'd0; mRet2 = 4'd0;
        end else if (bus.flush || (!bus.hold && !bus.inValid)) begin
            mWe = 1'b0; mReg = 5'd0; mData = 32'd0; mPc = RPC; mMis = 1'b0; mKnown = 1'b1;
        end else if (bus.hold) begin
            mMis = 1'b0;
        end else begin
            mRet  = mRet + 32'd1;
            mRet2 = mRet2 + 4'd1;
            mPc   = bus.inPC;
            mMis  = isMisaligned(int'(bus.inWbSel), int'(bus.inLoadType), int'(bus.inAddrLow));
            if (mMis) begin
                mWe = 1'b0; mData = 32'd0; mKnown = 1'b0;
            end else begin
                mWe    = bus.inRegWrite && (bus.inWriteReg != 5'd0);
                mReg   = bus.inWriteReg;
                mKnown = 1'b1;
                case (int'(bus.inWbSel))
                    1:       mData = loadValue(bus.inMemData, int'(bus.inLoadType),
                                               int'(bus.inAddrLow));
                    2:       mData = bus.inPC + 32'd8;
                    default: mData = bus.inAluResult;
                endcase
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s %s: got %h want %h", curTag, name, act, exp);
        end
    endtask

    task automatic checkAll();
        logic fv;
        fv = mWe && (mReg != 5'd0);
        chk("writeEnable", 32'(bus.writeEnable), 32'(mWe));
        chk("writeData", bus.writeData, mData);
        chk("PCReg", bus.PCReg, mPc);
        chk("fwdValid", 32'(bus.fwdValid), 32'(fv));
        chk("fwdData", bus.fwdData, mData);
        chk("misalign", 32'(bus.misalign), 32'(mMis));
        chk("retired", bus.retired, mRet);
        chk("small.writeEnable", 32'(bus2.writeEnable), 32'(mWe));
        chk("small.writeData", bus2.writeData, mData);
        chk("small.PCReg", bus2.PCReg, mPc);
        chk("small.fwdValid", 32'(bus2.fwdValid), 32'(fv));
        chk("small.fwdData", bus2.fwdData, mData);
        chk("small.misalign", 32'(bus2.misalign), 32'(mMis));
        chk("small.retired", 32'(bus2.retired), 32'(mRet2));
        if (mKnown) begin
            chk("writeReg", 32'(bus.writeReg), 32'(mReg));
            chk("fwdReg", 32'(bus.fwdReg), 32'(mReg));
            chk("small.writeReg", 32'(bus2.writeReg), 32'(mReg));
            chk("small.fwdReg", 32'(bus2.fwdReg), 32'(mReg));
        end
    endtask

    task automatic step();
        @(posedge clk);
        modelEdge();
        #1;
        checkAll();
    endtask

    task automatic setInstr(input logic valid, input logic [31:0] pc, input logic rw,
                            input logic [4:0] wr, input logic [1:0] sel,
                            input logic [31:0] alu, input logic [31:0] mem,
                            input logic [2:0] lt, input logic [1:0] al);
        bus.inValid = valid; bus.inPC = pc; bus.inRegWrite = rw; bus.inWriteReg = wr;
        bus.inWbSel = sel; bus.inAluResult = alu; bus.inMemData = mem;
        bus.inLoadType = lt; bus.inAddrLow = al;
    endtask

    task automatic randInputs();
        setInstr(1'($urandom_range(0, 5) != 0), $urandom, 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), $urandom, $urandom,
                 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
        bus.hold  = ($urandom_range(0, 7) == 0);
        bus.flush = ($urandom_range(0, 9) == 0);
        reset     = ($urandom_range(0, 49) == 0);
    endtask

    initial begin
        vecs[0]  = mkv(1, 32'h3004, 1, 10, 0, 32'd16, 0, 0, 0, 1, 10, 32'd16, 32'h3004, 0);
        vecs[1]  = mkv(1, 32'h3008, 1, 0, 0, 32'd3, 0, 0, 0, 0, 0, 32'd3, 32'h3008, 0);
        vecs[2]  = mkv(1, 32'h300C, 1, 5, 1, 0, M, 1, 3, 1, 5, 32'hFFFFFF80, 32'h300C, 0);
        vecs[3]  = mkv(1, 32'h3010, 1, 6, 1, 0, M, 2, 1, 1, 6, 32'h0000007F, 32'h3010, 0);
        vecs[4]  = mkv(1, 32'h3014, 1, 7, 1, 0, M, 3, 2, 1, 7, 32'hFFFF80FF, 32'h3014, 0);
        vecs[5]  = mkv(1, 32'h3018, 1, 8, 1, 0, M, 4, 0, 1, 8, 32'h00007F01, 32'h3018, 0);
        vecs[6]  = mkv(1, 32'h301C, 1, 9, 1, 0, M, 0, 2, 0, 9, 32'd0, 32'h301C, 1);
        vecs[7]  = mkv(1, 32'hFFFFFFFC, 1, 31, 2, 0, 0, 0, 0, 1, 31, 32'd4, 32'hFFFFFFFC, 0);
        vecs[8]  = mkv(1, 32'h3020, 1, 11, 1, 0, M, 0, 0, 1, 11, M, 32'h3020, 0);
        vecs[9]  = mkv(1, 32'h3024, 1, 12, 3, 32'hDEADBEEF, M, 0, 0, 1, 12, 32'hDEADBEEF,
                       32'h3024, 0);
        vecs[10] = mkv(1, 32'h3028, 1, 13, 1, 0, M, 4, 3, 0, 13, 32'd0, 32'h3028, 1);
        vecs[11] = mkv(1, 32'h302C, 0, 14, 0, 32'h55, 0, 0, 0, 0, 14, 32'h55, 32'h302C, 0);
        vecs[12] = mkv(0, 32'h3030, 1, 15, 0, 32'h77, 0, 0, 0, 0, 0, 32'd0, RPC, 0);
        vecs[13] = mkv(1, 32'h3030, 1, 15, 1, 0, M, 5, 1, 0, 15, 32'd0, 32'h3030, 1);
        vecs[14] = mkv(1, 32'h3034, 1, 16, 1, 0, M, 1, 0, 1, 16, 32'd1, 32'h3034, 0);

        // Reset then idle
        curTag = "reset";
        setInstr(0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.hold = 0; bus.flush = 0; reset = 1;
        step();
        step();
        chk("rstWe", 32'(bus.writeEnable), 32'd0);
        chk("rstPC", bus.PCReg, RPC);
        chk("rstRetired", bus.retired, 32'd0);
        reset = 0;

        // Directed vectors
        for (int i = 0; i < NV; i++) begin
            curTag = $sformatf("vec%0d", i);
            setInstr(vecs[i].valid, vecs[i].pc, vecs[i].rw, vecs[i].wr, vecs[i].sel,
                     vecs[i].alu, vecs[i].mem, vecs[i].lt, vecs[i].al);
            step();
            chk("tWe", 32'(bus.writeEnable), 32'(vecs[i].eWe));
            chk("tData", bus.writeData, vecs[i].eData);
            chk("tPC", bus.PCReg, vecs[i].ePc);
            chk("tMis", 32'(bus.misalign), 32'(vecs[i].eMis));
            if (!vecs[i].eMis) chk("tReg", 32'(bus.writeReg), 32'(vecs[i].eReg));
        end

        // Hold for three cycles freezes everything
        curTag = "hold";
        bus.hold = 1;
        for (int i = 0; i < 3; i++) begin
            setInstr(1, $urandom, 1, 5'd20, 0, $urandom, 0, 0, 0);
            step();
        end
        chk("holdWe", 32'(bus.writeEnable), 32'd1);
        chk("holdData", bus.writeData, 32'd1);
        chk("holdPC", bus.PCReg, 32'h3034);
        chk("holdRetired", bus.retired, 32'd14);

        // Misalign pulse is cleared by a following hold
        curTag = "misHold";
        bus.hold = 0;
        setInstr(1, 32'h4000, 1, 3, 1, 0, M, 0, 1);
        step();
        chk("misSet", 32'(bus.misalign), 32'd1);
        bus.hold = 1;
        step();
        chk("misCleared", 32'(bus.misalign), 32'd0);
        chk("misHoldPC", bus.PCReg, 32'h4000);

        // Flush beats hold
        curTag = "flushHold";
        bus.flush = 1;
        setInstr(1, 32'h5000, 1, 4, 0, 32'h99, 0, 0, 0);
        step();
        chk("fhWe", 32'(bus.writeEnable), 32'd0);
        chk("fhPC", bus.PCReg, RPC);
        chk("fhRetired", bus.retired, 32'd15);

        // Reset beats flush and clears the counter
        curTag = "resetFlush";
        reset = 1;
        step();
        chk("rfRetired", bus.retired, 32'd0);
        chk("rfPC", bus.PCReg, RPC);
        reset = 0; bus.flush = 0; bus.hold = 0;

        // Counter wrap on the narrow instance
        curTag = "wrap";
        for (int i = 0; i < 15; i++) begin
            setInstr(1, 32'h6000 + 32'(4 * i), 1, 5'd2, 0, 32'(i), 0, 0, 0);
            step();
        end
        chk("wrap15", 32'(bus2.retired), 32'd15);
        setInstr(1, 32'h6100, 1, 5'd2, 0, 32'd7, 0, 0, 0);
        step();
        chk("wrap0", 32'(bus2.retired), 32'd0);
        chk("noWrap16", bus.retired, 32'd16);

        // Randomized stimulus
        for (int n = 0; n < 400; n++) begin
            curTag = $sformatf("rand%0d", n);
            randInputs();
            step();
        end

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
